pc_branch_unit: RTL and testbench

Decode-stage control-flow resolver that drives the fetch program counter. Each cycle it evaluates the branch or jump in decode against its register operands and emits the PC action (`None`, `Inc`, `Offset`, `Jump`) with an offset or jump field. It compensates the offset for how far fetch has already advanced, and sequences the MIPS branch delay slot. It also raises the squash for the wrong-path instruction.

---
 rtl/pc_branch_unit_pkg.sv | 28 ++
 rtl/pc_branch_unit_if.sv | 33 +++
 rtl/pc_branch_cond.sv | 31 +++
 rtl/pc_branch_unit.sv | 109 ++++++++++
 tb/tb_pc_branch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared types for the decode-stage branch resolver: PC actions, branch kinds
// and the resolver FSM state.
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'd0,
        ACT_INC    = 2'd1,
        ACT_OFFSET = 2'd2,
        ACT_JUMP   = 2'd3
    } pc_action_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_J    = 3'd1,
        BR_BEQ  = 3'd2,
        BR_BNE  = 3'd3,
        BR_BLEZ = 3'd4,
        BR_BGTZ = 3'd5,
        BR_BLTZ = 3'd6,
        BR_BGEZ = 3'd7
    } pc_branch_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } br_state_t;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode-to-PC bundle: branch operands in, PC action / offset / jump out.
interface pc_branch_unit_if
    import pc_branch_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 16,
    parameter int JUMP_W   = 22
);
    // br_* are consumed only when the resolver is idle and stall is low;
    // there is no backpressure beyond stall and busy.
    logic                stall;
    logic                br_valid;
    pc_branch_t          br_kind;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [OFFSET_W-1:0] imm;
    logic [JUMP_W-1:0]   target;
    pc_action_t          act;
    logic [OFFSET_W:0]   offset;
    logic [JUMP_W-1:0]   jump;
    logic                flush;
    logic                busy;

    modport master (
        output stall, br_valid, br_kind, rs_val, rt_val, imm, target,
        input  act, offset, jump, flush, busy
    );

    modport slave (
        input  stall, br_valid, br_kind, rs_val, rt_val, imm, target,
        output act, offset, jump, flush, busy
    );
endinterface

// File: rtl/pc_branch_cond.sv
// Branch condition evaluator: signed compares of rs against zero or rt.
module pc_branch_cond
    import pc_branch_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  pc_branch_t        kind,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              taken
);
    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs[DATA_W-1];
    assign rs_zero = (rs == '0);

    always_comb begin
        taken = 1'b0;
        case (kind)
            BR_J:    taken = 1'b1;
            BR_BEQ:  taken = (rs == rt);
            BR_BNE:  taken = (rs != rt);
            BR_BLEZ: taken = rs_neg | rs_zero;
            BR_BGTZ: taken = ~rs_neg & ~rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = ~rs_neg;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_branch_unit.sv
// Decode-stage control-flow resolver: issues the PC action, sequences the
// optional delay slot and squashes the wrong-path fetch.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int OFFSET_W   = 16,
    parameter int JUMP_W     = 22,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pc_branch_unit_if.slave   bus,
    output br_state_t         dbg_state
);
    localparam logic [OFFSET_W:0] OFF_ONE = {{OFFSET_W{1'b0}}, 1'b1};

    // The jump field is word-indexed and must fit inside the PC.
    if (ADDR_W < JUMP_W + 2) begin : g_bad_addr_w
        $error("pc_branch_unit: ADDR_W too small for JUMP_W");
    end

    br_state_t         state, state_nx;
    pc_branch_t        kind;
    logic              taken;
    logic              load;
    logic              pend_jump;
    logic [OFFSET_W:0] pend_off;
    logic [JUMP_W-1:0] pend_tgt;
    logic [OFFSET_W:0] imm_sext;
    logic [OFFSET_W:0] imm_adj;

    assign kind = bus.br_valid ? bus.br_kind : BR_NONE;

    pc_branch_cond #(.DATA_W(DATA_W)) u_cond (
        .kind  (kind),
        .rs    (bus.rs_val),
        .rt    (bus.rt_val),
        .taken (taken)
    );

    // Fetch is one instruction further along by the time a slot redirect
    // issues, so the pending offset is pulled back by one.
    assign imm_sext = {bus.imm[OFFSET_W-1], bus.imm};
    assign imm_adj  = imm_sext - OFF_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend_jump <= 1'b0;
            pend_off  <= '0;
            pend_tgt  <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                pend_jump <= (kind == BR_J);
                pend_off  <= imm_adj;
                pend_tgt  <= bus.target;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        bus.act    = ACT_NONE;
        bus.offset = '0;
        bus.jump   = '0;
        bus.flush  = 1'b0;
        if (!rst && !bus.stall) begin
            case (state)
                ST_IDLE: begin
                    if (!taken) begin
                        bus.act = ACT_INC;
                    end else if (DELAY_SLOT) begin
                        bus.act  = ACT_INC;
                        load     = 1'b1;
                        state_nx = ST_SLOT;
                    end else begin
                        bus.flush = 1'b1;
                        if (kind == BR_J) begin
                            bus.act  = ACT_JUMP;
                            bus.jump = bus.target;
                        end else begin
                            bus.act    = ACT_OFFSET;
                            bus.offset = imm_sext;
                        end
                    end
                end
                ST_SLOT: begin
                    bus.flush = 1'b1;
                    state_nx  = ST_IDLE;
                    if (pend_jump) begin
                        bus.act  = ACT_JUMP;
                        bus.jump = pend_tgt;
                    end else begin
                        bus.act    = ACT_OFFSET;
                        bus.offset = pend_off;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == ST_SLOT) && !rst;
    assign dbg_state = state;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus randomized traffic on a
// no-delay-slot and a delay-slot instance, checked against a queue model.
module tb_pc_branch_unit;
    import pc_branch_unit_pkg::*;

    localparam int DW = 32;
    localparam int OW = 16;
    localparam int JW = 22;

    typedef logic [2+OW+1+JW+2-1:0] obs_t;

    typedef struct {
        bit              is_jump;
        logic [OW:0]     off;
        logic [JW-1:0]   tgt;
    } redirect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.DATA_W(DW), .OFFSET_W(OW), .JUMP_W(JW)) if0 ();
    pc_branch_unit_if #(.DATA_W(DW), .OFFSET_W(OW), .JUMP_W(JW)) if1 ();
    br_state_t dbg0, dbg1;

    pc_branch_unit #(.DATA_W(DW), .OFFSET_W(OW), .JUMP_W(JW), .DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0)
    );
    pc_branch_unit #(.DATA_W(DW), .OFFSET_W(OW), .JUMP_W(JW), .DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    redirect_t pend_q[$];

    function automatic obs_t pack(pc_action_t a, logic [OW:0] o, logic [JW-1:0] j,
                                  logic f, logic b);
        return {a, o, j, f, b};
    endfunction

    function automatic obs_t sample(bit ds);
        if (ds) return {if1.act, if1.offset, if1.jump, if1.flush, if1.busy};
        return {if0.act, if0.offset, if0.jump, if0.flush, if0.busy};
    endfunction

    function automatic bit taken_ref(logic v, pc_branch_t k, logic [DW-1:0] rs, logic [DW-1:0] rt);
        int s;
        s = $signed(rs);
        if (!v) return 1'b0;
        case (k)
            BR_J:    return 1'b1;
            BR_BEQ:  return rs == rt;
            BR_BNE:  return rs != rt;
            BR_BLEZ: return s <= 0;
            BR_BGTZ: return s > 0;
            BR_BLTZ: return s < 0;
            BR_BGEZ: return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(bit ds, logic st, logic v, pc_branch_t k, logic [DW-1:0] rs,
                         logic [DW-1:0] rt, logic [OW-1:0] imm, logic [JW-1:0] tgt);
        if (ds) begin
            if1.stall = st; if1.br_valid = v; if1.br_kind = k;
            if1.rs_val = rs; if1.rt_val = rt; if1.imm = imm; if1.target = tgt;
        end else begin
            if0.stall = st; if0.br_valid = v; if0.br_kind = k;
            if0.rs_val = rs; if0.rt_val = rt; if0.imm = imm; if0.target = tgt;
        end
    endtask

    task automatic idle_both();
        drive(1'b0, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, BR_J, '0, '0, '0, 22'h5);
            drive(1'b1, 1'b0, 1'b1, BR_J, '0, '0, '0, 22'h5);
            #1;
            exp = pack(ACT_NONE, '0, '0, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                got = sample(d[0]);
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL reset_hold ds%0d c%0d got %h want %h", d, c, got, exp);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle_both();
        #1;
        exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            got = sample(d[0]);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release ds%0d got %h want %h", d, got, exp);
            end
        end
    endtask

    task automatic test_ds0_beq();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, BR_BEQ, 32'd5, 32'd5, 16'd16, '0);
        #1;
        got = sample(1'b0); exp = pack(ACT_OFFSET, 17'd16, '0, 1'b1, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ds0_beq got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b0); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ds0_beq_next got %h want %h", got, exp); end
    endtask

    task automatic test_ds0_back_to_back();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, BR_BNE, 32'd3, 32'd4, 16'd5, '0);
        #1;
        got = sample(1'b0); exp = pack(ACT_OFFSET, 17'd5, '0, 1'b1, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_bne got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, BR_J, '0, '0, '0, 22'h3FFFFF);
        #1;
        got = sample(1'b0); exp = pack(ACT_JUMP, '0, 22'h3FFFFF, 1'b1, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_j got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, BR_BLTZ, 32'hFFFF_FFFF, '0, 16'hFFFF, '0);
        #1;
        got = sample(1'b0); exp = pack(ACT_OFFSET, 17'h1FFFF, '0, 1'b1, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b_bltz got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
    endtask

    task automatic test_ds1_bne();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BNE, 32'd1, 32'd2, 16'hFFFC, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ds1_bne_c0 got %h want %h", got, exp); end
        // A taken branch presented in the slot must be ignored.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BEQ, 32'd9, 32'd9, 16'd7, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_OFFSET, 17'h1FFFB, '0, 1'b1, 1'b1);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ds1_bne_c1 got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL ds1_bne_c2 got %h want %h", got, exp); end
    endtask

    task automatic test_ds1_cond();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BGEZ, 32'h8000_0000, '0, 16'd9, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL bgez_neg got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BLEZ, 32'd0, '0, 16'd3, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL blez_zero_c0 got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_OFFSET, 17'd2, '0, 1'b1, 1'b1);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL blez_zero_c1 got %h want %h", got, exp); end
    endtask

    task automatic test_ds1_jump_stall();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_J, '0, '0, '0, 22'h12345);
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL jstall_c0 got %h want %h", got, exp); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, BR_NONE, '0, '0, '0, 22'h0ABCD);
            #1;
            got = sample(1'b1); exp = pack(ACT_NONE, '0, '0, 1'b0, 1'b1);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL jstall_hold%0d got %h want %h", c, got, exp); end
        end
        n_tests++;
        if (dbg1 !== ST_SLOT) begin n_fail++; $display("FAIL jstall_state got %0d want %0d", dbg1, ST_SLOT); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_JUMP, '0, 22'h12345, 1'b1, 1'b1);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL jstall_issue got %h want %h", got, exp); end
    endtask

    task automatic test_ds1_min_imm_reset();
        obs_t got, exp;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BEQ, 32'd7, 32'd7, 16'h8000, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_OFFSET, 17'h17FFF, '0, 1'b1, 1'b1);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL min_imm got %h want %h", got, exp); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, BR_BEQ, 32'd7, 32'd7, 16'h8000, '0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, BR_NONE, '0, '0, '0, '0);
        #1;
        got = sample(1'b1); exp = pack(ACT_NONE, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL slot_reset got %h want %h", got, exp); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        got = sample(1'b1); exp = pack(ACT_INC, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL slot_reset_release got %h want %h", got, exp); end
    endtask

    task automatic test_random(bit ds, int n);
        logic st, v;
        pc_branch_t k;
        logic [DW-1:0] rs, rt;
        logic [OW-1:0] imm;
        logic [JW-1:0] tg;
        pc_action_t e_act;
        logic [OW:0] e_off;
        logic [JW-1:0] e_jmp;
        logic e_fl, e_busy;
        redirect_t r;
        int disp;
        obs_t got, exp;
        pend_q.delete();
        for (int c = 0; c < n; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            v   = ($urandom_range(0, 3) != 0);
            k   = pc_branch_t'($urandom_range(0, 7));
            rs  = pick_operand();
            rt  = $urandom_range(0, 1) ? rs : pick_operand();
            imm = OW'($urandom);
            tg  = JW'($urandom);
            e_act = ACT_NONE; e_off = '0; e_jmp = '0; e_fl = 1'b0;
            e_busy = (pend_q.size() != 0);
            if (st) begin
                e_act = ACT_NONE;
            end else if (pend_q.size() != 0) begin
                r = pend_q.pop_front();
                e_fl = 1'b1;
                if (r.is_jump) begin e_act = ACT_JUMP; e_jmp = r.tgt; end
                else begin e_act = ACT_OFFSET; e_off = r.off; end
            end else if (!taken_ref(v, k, rs, rt)) begin
                e_act = ACT_INC;
            end else if (ds) begin
                e_act = ACT_INC;
                disp  = $signed(imm) - 1;
                pend_q.push_back('{k == BR_J, disp[OW:0], tg});
            end else begin
                e_fl = 1'b1;
                disp = $signed(imm);
                if (k == BR_J) begin e_act = ACT_JUMP; e_jmp = tg; end
                else begin e_act = ACT_OFFSET; e_off = disp[OW:0]; end
            end
            @(negedge clk);
            drive(ds, st, v, k, rs, rt, imm, tg);
            #1;
            got = sample(ds);
            exp = pack(e_act, e_off, e_jmp, e_fl, e_busy);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_ds%0d_c%0d kind=%0d got %h want %h", ds, c, k, got, exp);
            end
        end
        @(negedge clk);
        idle_both();
    endtask

    initial begin
        idle_both();
        test_reset();
        test_ds0_beq();
        test_ds0_back_to_back();
        test_ds1_bne();
        test_ds1_cond();
        test_ds1_jump_stall();
        test_ds1_min_imm_reset();
        test_random(1'b0, 300);
        test_random(1'b1, 400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
